psc_serializer: RTL and testbench



---
 rtl/psc_pkg.sv | 15 +
 rtl/psc_hold_buf.sv | 30 +++
 rtl/psc_serializer.sv | 101 ++++++++++
 tb/tb_psc_serializer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psc_pkg.sv
// Shared definitions for the parallel/serial converter pair.
package psc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } psc_state_t;

    localparam int PSC_DEFAULT_WIDTH = 2;

    function automatic int ctr_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/psc_hold_buf.sv
// One-entry symbol holding register with a full flag.
module psc_hold_buf
    import psc_pkg::*;
#(
    parameter int WIDTH = PSC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            full <= 1'b0;
        end else if (wr) begin
            dout <= din;
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

    wr_rd_exclusive: assert property (@(posedge clk) disable iff (reset) !(wr && rd));

endmodule

// File: rtl/psc_serializer.sv
// Parallel-to-serial converter: valid/ready symbol input, one bit per en strobe.
module psc_serializer
    import psc_pkg::*;
#(
    parameter int WIDTH     = PSC_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CW = ctr_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    psc_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shifter, shifter_nx, shifted;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full, hold_wr, hold_rd;
    logic             xfer, last_bit;

    assign in_ready = !reset && !hold_full;
    assign xfer     = in_valid && in_ready;
    assign last_bit = en && (cnt == LAST);
    assign shifted  = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};

    assign dout       = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
    assign dout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT) || hold_full;

    psc_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .wr   (hold_wr),
        .rd   (hold_rd),
        .din  (in_data),
        .dout (hold_data),
        .full (hold_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shifter <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            shifter <= shifter_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shifter_nx = shifter;
        hold_wr    = 1'b0;
        hold_rd    = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    shifter_nx = in_data;
                    cnt_nx     = '0;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (en && !last_bit) begin
                    shifter_nx = shifted;
                    cnt_nx     = cnt + 1'b1;
                end else if (last_bit) begin
                    cnt_nx = '0;
                    if (hold_full) begin
                        shifter_nx = hold_data;
                        hold_rd    = 1'b1;
                    end else if (xfer) begin
                        shifter_nx = in_data;
                    end else begin
                        shifter_nx = '0;
                        state_nx   = IDLE;
                    end
                end
                // A transfer on the final bit goes straight to the shifter, not the buffer.
                if (xfer && !last_bit) begin
                    hold_wr = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_psc_serializer.sv
// Scoreboard bench for psc_serializer: 2-bit MSB-first and 4-bit LSB-first instances.
module tb_psc_serializer;

    logic       clk;
    logic       reset;
    logic       en_a, in_valid_a, in_ready_a, dout_a, dout_valid_a, busy_a;
    logic [1:0] in_data_a;
    logic       en_b, in_valid_b, in_ready_b, dout_b, dout_valid_b, busy_b;
    logic [3:0] in_data_b;

    int   checks   = 0;
    int   failures = 0;
    logic qa [$];
    logic qb [$];
    logic ea, eb;

    psc_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .dout(dout_a), .dout_valid(dout_valid_a), .busy(busy_a)
    );

    psc_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard A: bits are consumed on edges where en is high while dout_valid.
    always @(negedge clk) begin
        if (reset) begin
            qa.delete();
        end else begin
            if (en_a && dout_valid_a) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL sb_a_extra: got dout=%0b, expected no symbol bit", dout_a);
                end else begin
                    ea = qa.pop_front();
                    if (dout_a !== ea) begin
                        failures++;
                        $display("FAIL sb_a_bit: got %0b, expected %0b", dout_a, ea);
                    end
                end
            end
            if (in_valid_a && in_ready_a) begin
                qa.push_back(in_data_a[1]);
                qa.push_back(in_data_a[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            qb.delete();
        end else begin
            if (en_b && dout_valid_b) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_b_extra: got dout=%0b, expected no symbol bit", dout_b);
                end else begin
                    eb = qb.pop_front();
                    if (dout_b !== eb) begin
                        failures++;
                        $display("FAIL sb_b_bit: got %0b, expected %0b", dout_b, eb);
                    end
                end
            end
            if (in_valid_b && in_ready_b) begin
                for (int i = 0; i < 4; i++) qb.push_back(in_data_b[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en_a = 0; in_valid_a = 0; in_data_a = '0;
        en_b = 0; in_valid_b = 0; in_data_b = '0;
        tick();
        tick();
        checks++;
        if ({dout_a, dout_valid_a, busy_a, in_ready_a} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got {dout,valid,busy,ready}=%b, expected 0000",
                     {dout_a, dout_valid_a, busy_a, in_ready_a});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %0b, expected 1", in_ready_a);
        end
        tick();
    endtask

    task automatic test_single();
        int n = 0;
        en_a = 1; in_valid_a = 1; in_data_a = 2'b10;
        tick();
        in_valid_a = 0;
        for (int i = 0; i < 10; i++) begin
            if (dout_valid_a) n++;
            tick();
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL single_valid_cycles: got %0d, expected 2", n);
        end
        checks++;
        if ({dout_a, dout_valid_a, busy_a} !== 3'b000) begin
            failures++;
            $display("FAIL single_idle: got {dout,valid,busy}=%b, expected 000",
                     {dout_a, dout_valid_a, busy_a});
        end
        checks++;
        if (qa.size() !== 0) begin
            failures++;
            $display("FAIL single_residual: got %0d pending bits, expected 0", qa.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] syms [3];
        logic [5:0] exp_rdy;
        int idx = 0;
        syms[0] = 2'b01; syms[1] = 2'b11; syms[2] = 2'b10;
        exp_rdy = 6'b101011;
        en_a = 1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                checks++;
                if (in_ready_a !== exp_rdy[c]) begin
                    failures++;
                    $display("FAIL b2b_ready c=%0d: got %0b, expected %0b", c, in_ready_a, exp_rdy[c]);
                end
            end
            if (c >= 1) begin
                checks++;
                if (dout_valid_a !== (c <= 6)) begin
                    failures++;
                    $display("FAIL b2b_valid c=%0d: got %0b, expected %0b", c, dout_valid_a, c <= 6);
                end
            end
            in_valid_a = (idx < 3);
            in_data_a  = (idx < 3) ? syms[idx] : 2'b00;
            if (in_valid_a && in_ready_a) idx++;
            tick();
        end
        in_valid_a = 0;
        checks++;
        if (idx !== 3 || qa.size() !== 0) begin
            failures++;
            $display("FAIL b2b_drain: got sent=%0d pending=%0d, expected sent=3 pending=0", idx, qa.size());
        end
    endtask

    task automatic test_bypass();
        en_a = 1;
        for (int c = 0; c < 7; c++) begin
            if (c >= 1 && c <= 5) begin
                checks++;
                if (dout_valid_a !== (c <= 4)) begin
                    failures++;
                    $display("FAIL bypass_valid c=%0d: got %0b, expected %0b", c, dout_valid_a, c <= 4);
                end
            end
            if (c == 3) begin
                checks++;
                if (in_ready_a !== 1'b1) begin
                    failures++;
                    $display("FAIL bypass_hold_empty: got in_ready=%0b, expected 1", in_ready_a);
                end
            end
            in_valid_a = (c == 0) || (c == 2);
            in_data_a  = (c == 0) ? 2'b10 : 2'b01;
            tick();
        end
        in_valid_a = 0;
        checks++;
        if (qa.size() !== 0) begin
            failures++;
            $display("FAIL bypass_residual: got %0d pending bits, expected 0", qa.size());
        end
    endtask

    task automatic test_slow_en();
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (c >= 1 && c <= 8) begin
                if ({dout_valid_a, dout_a} !== {1'b1, c <= 4}) begin
                    failures++;
                    $display("FAIL slow_bit c=%0d: got {valid,dout}=%b, expected %b", c,
                             {dout_valid_a, dout_a}, {1'b1, c <= 4});
                end
            end else if (dout_valid_a !== 1'b0) begin
                failures++;
                $display("FAIL slow_idle c=%0d: got valid=%0b, expected 0", c, dout_valid_a);
            end
            en_a       = (c % 4 == 0);
            in_valid_a = (c == 0);
            in_data_a  = 2'b10;
            tick();
        end
        in_valid_a = 0;
    endtask

    task automatic test_lsb_w4();
        int n = 0;
        en_b = 1; in_valid_b = 1; in_data_b = 4'b0011;
        tick();
        in_valid_b = 0;
        for (int i = 0; i < 8; i++) begin
            if (dout_valid_b) n++;
            tick();
        end
        checks++;
        if (n !== 4 || qb.size() !== 0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL lsb_w4: got valid_cycles=%0d pending=%0d busy=%0b, expected 4 0 0",
                     n, qb.size(), busy_b);
        end
    endtask

    task automatic test_reset_mid();
        en_a = 1; in_valid_a = 1; in_data_a = 2'b10;
        tick();
        in_data_a = 2'b01;
        tick();
        in_valid_a = 0;
        reset = 1'b1;
        #1;
        checks++;
        if ({dout_a, dout_valid_a, busy_a, in_ready_a} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_outputs: got {dout,valid,busy,ready}=%b, expected 0000",
                     {dout_a, dout_valid_a, busy_a, in_ready_a});
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready_a, busy_a} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_release: got {ready,busy}=%b, expected 10", {in_ready_a, busy_a});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({dout_valid_a, dout_a} !== 2'b00) begin
                failures++;
                $display("FAIL midreset_residual i=%0d: got {valid,dout}=%b, expected 00", i,
                         {dout_valid_a, dout_a});
            end
        end
    endtask

    task automatic test_en_stall();
        int t = 0;
        en_a = 0; in_valid_a = 1; in_data_a = 2'b10;
        tick();
        in_valid_a = 0; en_a = 1;
        tick();
        en_a = 0; in_valid_a = 1; in_data_a = 2'b11;
        tick();
        in_valid_a = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({dout_a, in_ready_a, dout_valid_a} !== 3'b001) begin
                failures++;
                $display("FAIL stall i=%0d: got {dout,ready,valid}=%b, expected 001", i,
                         {dout_a, in_ready_a, dout_valid_a});
            end
            tick();
        end
        en_a = 1;
        while (busy_a && t < 10) begin
            tick();
            t++;
        end
        checks++;
        if (busy_a !== 1'b0 || qa.size() !== 0) begin
            failures++;
            $display("FAIL stall_resume: got busy=%0b pending=%0d after %0d cycles, expected 0 0",
                     busy_a, qa.size(), t);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_slow_en();
        test_lsb_w4();
        test_reset_mid();
        test_en_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
